// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: turns the UART_Rx byte stream into checked command frames.
// Wire format: SOF, LEN, LEN payload bytes, CHK (XOR of LEN and the payload).
// A good frame is held in the buffer until downstream acks it. Bad LEN, bad
// checksum, inter-byte timeout and overrun-while-held are reported on o_err.
//
// Handshake: o_frame_valid rises the cycle after a good CHK byte and stays
// high until a cycle with i_frame_ack=1 is sampled; it drops on the next
// cycle. Acks seen while o_frame_valid=0 have no effect.
module uart_rx_frame_ctrl #(
  parameter int         CLKS_PER_BIT  = 868,
  parameter int         MAX_PAYLOAD   = 16,
  parameter logic [7:0] SOF_BYTE      = 8'hA5,
  parameter int         TIMEOUT_BYTES = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_rx_dv,
  input  logic [7:0]                       i_rx_byte,
  output logic                             o_frame_valid,
  output logic [$clog2(MAX_PAYLOAD):0]     o_frame_len,
  input  logic                             i_frame_ack,
  input  logic [$clog2(MAX_PAYLOAD)-1:0]   i_rd_addr,
  output logic [7:0]                       o_rd_data,
  output logic                             o_err,
  output logic [1:0]                       o_err_code,
  output logic [7:0]                       o_err_count,
  output logic                             o_busy,
  output logic [2:0]                       o_dbg_state
);

  localparam int         AW        = $clog2(MAX_PAYLOAD);
  localparam int         LW        = AW + 1;
  localparam int         TMO_LIMIT = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;
  localparam int         TW        = $clog2(TMO_LIMIT + 1);
  localparam logic [7:0] MAX_B     = 8'(MAX_PAYLOAD);
  // Counter value one clock before it reaches the limit: the terminal cycle.
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_LIMIT - 1);

  localparam logic [1:0] E_OVERRUN = 2'b00;
  localparam logic [1:0] E_BADLEN  = 2'b01;
  localparam logic [1:0] E_CHKSUM  = 2'b10;
  localparam logic [1:0] E_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [LW-1:0]  len_q, len_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [7:0]     chk_q, chk_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           valid_d;
  logic [LW-1:0]  flen_d;
  logic           err_d;
  logic [1:0]     code_d;
  logic           wr_en;
  logic           tmo_active;
  logic           tmo_hit;
  logic [7:0]     buf_mem [MAX_PAYLOAD];

  assign o_dbg_state = state_q;
  assign tmo_active  = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
  // A byte in the terminal cycle wins over the timeout.
  assign tmo_hit     = tmo_active && !i_rx_dv && (tmo_q == TMO_LAST);

  // Next-state, frame bookkeeping and error decode.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    chk_d   = chk_q;
    valid_d = o_frame_valid;
    flen_d  = o_frame_len;
    err_d   = 1'b0;
    code_d  = o_err_code;
    wr_en   = 1'b0;
    tmo_d   = (tmo_active && !i_rx_dv) ? tmo_q + 1'b1 : '0;

    if (tmo_hit) begin
      err_d   = 1'b1;
      code_d  = E_TIMEOUT;
      state_d = S_IDLE;
      tmo_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_rx_dv && i_rx_byte == SOF_BYTE) state_d = S_LEN;
        end
        S_LEN: begin
          if (i_rx_dv) begin
            if (i_rx_byte == 8'd0 || i_rx_byte > MAX_B) begin
              err_d   = 1'b1;
              code_d  = E_BADLEN;
              state_d = S_IDLE;
            end else begin
              len_d   = i_rx_byte[LW-1:0];
              chk_d   = i_rx_byte;
              idx_d   = '0;
              state_d = S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (i_rx_dv) begin
            wr_en = 1'b1;
            chk_d = chk_q ^ i_rx_byte;
            idx_d = idx_q + 1'b1;
            if ({1'b0, idx_q} == len_q - LW'(1)) state_d = S_CHK;
          end
        end
        S_CHK: begin
          if (i_rx_dv) begin
            if (i_rx_byte == chk_q) begin
              state_d = S_HOLD;
              valid_d = 1'b1;
              flen_d  = len_q;
            end else begin
              err_d   = 1'b1;
              code_d  = E_CHKSUM;
              state_d = S_IDLE;
            end
          end
        end
        S_HOLD: begin
          if (i_frame_ack) begin
            // Release wins; a byte in the same cycle is judged as if in IDLE.
            valid_d = 1'b0;
            state_d = (i_rx_dv && i_rx_byte == SOF_BYTE) ? S_LEN : S_IDLE;
          end else if (i_rx_dv) begin
            err_d  = 1'b1;
            code_d = E_OVERRUN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      idx_q         <= '0;
      chk_q         <= '0;
      tmo_q         <= '0;
      o_frame_valid <= 1'b0;
      o_frame_len   <= '0;
      o_rd_data     <= '0;
      o_err         <= 1'b0;
      o_err_code    <= 2'b00;
      o_err_count   <= '0;
      o_busy        <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      chk_q         <= chk_d;
      tmo_q         <= tmo_d;
      o_frame_valid <= valid_d;
      o_frame_len   <= flen_d;
      o_rd_data     <= buf_mem[i_rd_addr];
      o_err         <= err_d;
      o_err_code    <= code_d;
      o_busy        <= (state_d != S_IDLE);
      if (err_d && o_err_count != 8'hFF) o_err_count <= o_err_count + 1'b1;
    end
  end

  // Payload buffer; contents are not reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) buf_mem[idx_q] <= i_rx_byte;
  end

endmodule
